// File: rtl/mem_stage.sv
// Memory stage of the 5-stage MIPS pipeline.
// Performs word/half/byte data-memory reads and writes, sign/zero-extends
// loads, forwards store data from write-back, holds the M/W pipeline register
// and publishes the destination register and result latency of the
// instruction in M.
// Optional build macro: DM_ALIGN_CHECK_EN. When it is defined, misaligned
// lw/sw/lh/lhu/sh raise AdErr_M, are suppressed as writes, and load 0.
module mem_stage #(
    parameter int          DM_WORDS = 1024,
    parameter logic [31:0] PC_RESET = 32'h0000_3004
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] IR_E2M,
    input  logic [31:0] PC4_E2M,
    input  logic [31:0] ALUout_E2M,
    input  logic [31:0] RD2_E2M,
    input  logic [4:0]  WhoNew_M2W,
    input  logic [31:0] WD2A3,
    output logic [31:0] IR_M2W,
    output logic [31:0] PC4_M2W,
    output logic [31:0] ALUout_M2W,
    output logic [31:0] DMout_M2W,
    output logic [4:0]  WhoNew_E2M,
    output logic [1:0]  TNew_E2M,
    output logic        AdErr_M
);

    localparam int AW = $clog2(DM_WORDS);

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_LB      = 6'b100000;
    localparam logic [5:0] OP_LH      = 6'b100001;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_LBU     = 6'b100100;
    localparam logic [5:0] OP_LHU     = 6'b100101;
    localparam logic [5:0] OP_SB      = 6'b101000;
    localparam logic [5:0] OP_SH      = 6'b101001;
    localparam logic [5:0] OP_SW      = 6'b101011;

    logic [31:0]   dm_r [DM_WORDS];
    logic [31:0]   ir_r;
    logic [31:0]   pc4_r;
    logic [31:0]   alu_r;
    logic [31:0]   dmout_r;

    logic [5:0]    op_s;
    logic [5:0]    funct_s;
    logic [4:0]    rt_s;
    logic [4:0]    rd_s;
    logic [AW-1:0] idx_s;
    logic [1:0]    boff_s;
    logic          is_load_s;
    logic          is_store_s;
    logic          ad_err_s;
    logic [31:0]   mfrd2_s;
    logic [31:0]   rd_word_s;
    logic [7:0]    rd_byte_s;
    logic [15:0]   rd_half_s;
    logic [31:0]   load_data_s;
    logic          wr_en_s;
    logic [31:0]   wr_word_s;
    logic [4:0]    who_new_s;

    assign op_s      = IR_E2M[31:26];
    assign funct_s   = IR_E2M[5:0];
    assign rt_s      = IR_E2M[20:16];
    assign rd_s      = IR_E2M[15:11];
    assign idx_s     = ALUout_E2M[AW+1:2];
    assign boff_s    = ALUout_E2M[1:0];
    assign rd_word_s = dm_r[idx_s];

    // Classify the M-stage opcode as load, store or neither.
    always_comb begin
        is_load_s  = 1'b0;
        is_store_s = 1'b0;
        case (op_s)
            OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU: is_load_s  = 1'b1;
            OP_SW, OP_SH, OP_SB:                 is_store_s = 1'b1;
            default: begin
                is_load_s  = 1'b0;
                is_store_s = 1'b0;
            end
        endcase
    end

    // Flag misaligned word/half accesses when alignment checking is built in.
    always_comb begin
        ad_err_s = 1'b0;
`ifdef DM_ALIGN_CHECK_EN
        case (op_s)
            OP_LW, OP_SW:         ad_err_s = (boff_s != 2'b00);
            OP_LH, OP_LHU, OP_SH: ad_err_s = boff_s[0];
            default:              ad_err_s = 1'b0;
        endcase
`else
        ad_err_s = 1'b0;
`endif
    end

    // Destination register of the instruction in M, for hazard detection.
    always_comb begin
        who_new_s = 5'd0;
        if (op_s == OP_SPECIAL) begin
            if ((funct_s == 6'b001000) || (funct_s[5:2] == 4'b0110) ||
                (funct_s == 6'b010001) || (funct_s == 6'b010011)) begin
                who_new_s = 5'd0;
            end else begin
                who_new_s = rd_s;
            end
        end else if (is_load_s || (op_s[5:3] == 3'b001)) begin
            who_new_s = rt_s;
        end else if (op_s == OP_JAL) begin
            who_new_s = 5'd31;
        end else begin
            who_new_s = 5'd0;
        end
    end

    // Store data comes from W when W is writing the register the store reads.
    always_comb begin
        mfrd2_s = RD2_E2M;
        if ((rt_s != 5'd0) && (rt_s == WhoNew_M2W)) begin
            mfrd2_s = WD2A3;
        end else begin
            mfrd2_s = RD2_E2M;
        end
    end

    // Pick the addressed byte and halfword lane out of the read word.
    always_comb begin
        rd_byte_s = rd_word_s[7:0];
        case (boff_s)
            2'd0:    rd_byte_s = rd_word_s[7:0];
            2'd1:    rd_byte_s = rd_word_s[15:8];
            2'd2:    rd_byte_s = rd_word_s[23:16];
            2'd3:    rd_byte_s = rd_word_s[31:24];
            default: rd_byte_s = rd_word_s[7:0];
        endcase
        if (boff_s[1]) begin
            rd_half_s = rd_word_s[31:16];
        end else begin
            rd_half_s = rd_word_s[15:0];
        end
    end

    // Extend the selected lane according to the load type.
    always_comb begin
        load_data_s = 32'd0;
        if (!is_load_s || ad_err_s) begin
            load_data_s = 32'd0;
        end else begin
            case (op_s)
                OP_LW:   load_data_s = rd_word_s;
                OP_LH:   load_data_s = {{16{rd_half_s[15]}}, rd_half_s};
                OP_LHU:  load_data_s = {16'd0, rd_half_s};
                OP_LB:   load_data_s = {{24{rd_byte_s[7]}}, rd_byte_s};
                OP_LBU:  load_data_s = {24'd0, rd_byte_s};
                default: load_data_s = 32'd0;
            endcase
        end
    end

    // Merge the store data into the addressed lanes of the current word.
    always_comb begin
        wr_word_s = rd_word_s;
        wr_en_s   = is_store_s && !ad_err_s;
        case (op_s)
            OP_SW: wr_word_s = mfrd2_s;
            OP_SH: begin
                if (boff_s[1]) begin
                    wr_word_s[31:16] = mfrd2_s[15:0];
                end else begin
                    wr_word_s[15:0] = mfrd2_s[15:0];
                end
            end
            OP_SB: begin
                case (boff_s)
                    2'd0:    wr_word_s[7:0]   = mfrd2_s[7:0];
                    2'd1:    wr_word_s[15:8]  = mfrd2_s[7:0];
                    2'd2:    wr_word_s[23:16] = mfrd2_s[7:0];
                    2'd3:    wr_word_s[31:24] = mfrd2_s[7:0];
                    default: wr_word_s        = rd_word_s;
                endcase
            end
            default: wr_word_s = rd_word_s;
        endcase
    end

    // Data memory: cleared by reset, single-cycle store on the rising edge.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DM_WORDS; i++) begin
                dm_r[i] <= 32'd0;
            end
        end else if (wr_en_s) begin
            dm_r[idx_s] <= wr_word_s;
        end
    end

    // M/W pipeline register, including the extended load data.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ir_r    <= 32'd0;
            pc4_r   <= PC_RESET;
            alu_r   <= 32'd0;
            dmout_r <= 32'd0;
        end else begin
            ir_r    <= IR_E2M;
            pc4_r   <= PC4_E2M;
            alu_r   <= ALUout_E2M;
            dmout_r <= load_data_s;
        end
    end

    assign IR_M2W     = ir_r;
    assign PC4_M2W    = pc4_r;
    assign ALUout_M2W = alu_r;
    assign DMout_M2W  = dmout_r;
    assign WhoNew_E2M = who_new_s;
    assign TNew_E2M   = {1'b0, is_load_s};
    assign AdErr_M    = ad_err_s;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a byte-addressed little-endian memory model
// predicts every M/W register value; a monitor compares after each edge.
module tb_mem_stage;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] IR_E2M = 32'd0;
    logic [31:0] PC4_E2M = 32'd0;
    logic [31:0] ALUout_E2M = 32'd0;
    logic [31:0] RD2_E2M = 32'd0;
    logic [4:0]  WhoNew_M2W = 5'd0;
    logic [31:0] WD2A3 = 32'd0;
    logic [31:0] IR_M2W;
    logic [31:0] PC4_M2W;
    logic [31:0] ALUout_M2W;
    logic [31:0] DMout_M2W;
    logic [4:0]  WhoNew_E2M;
    logic [1:0]  TNew_E2M;
    logic        AdErr_M;

    mem_stage dut (
        .Clk(Clk), .Reset(Reset), .IR_E2M(IR_E2M), .PC4_E2M(PC4_E2M),
        .ALUout_E2M(ALUout_E2M), .RD2_E2M(RD2_E2M), .WhoNew_M2W(WhoNew_M2W),
        .WD2A3(WD2A3), .IR_M2W(IR_M2W), .PC4_M2W(PC4_M2W),
        .ALUout_M2W(ALUout_M2W), .DMout_M2W(DMout_M2W),
        .WhoNew_E2M(WhoNew_E2M), .TNew_E2M(TNew_E2M), .AdErr_M(AdErr_M)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc4;
        logic [31:0] alu;
        logic [31:0] dm;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] mem_b [4096];
    int         checks = 0;
    int         fails = 0;
    bit         in_rst = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt,
                                          input logic [15:0] imm);
        logic [31:0] r;
        r = {op, 5'd4, rt, imm};
        return r;
    endfunction

    // Predict the response of the instruction currently on the inputs.
    task automatic model_step();
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  rt;
        logic [31:0] sd;
        logic [31:0] ld;
        logic [4:0]  who;
        bit          is_ld;
        bit          mis;
        int unsigned a;
        int unsigned wb;
        int unsigned hb;
        exp_t        e;
        op = IR_E2M[31:26];
        fn = IR_E2M[5:0];
        rt = IR_E2M[20:16];
        a  = ALUout_E2M % 4096;
        wb = a - (a % 4);
        hb = a - (a % 2);
        sd = ((rt != 5'd0) && (rt == WhoNew_M2W)) ? WD2A3 : RD2_E2M;
        is_ld = (op == 6'b100011) || (op == 6'b100001) || (op == 6'b100101) ||
                (op == 6'b100000) || (op == 6'b100100);
        mis = 1'b0;
`ifdef DM_ALIGN_CHECK_EN
        if ((op == 6'b100011) || (op == 6'b101011)) mis = (a % 4) != 0;
        if ((op == 6'b100001) || (op == 6'b100101) || (op == 6'b101001)) mis = (a % 2) != 0;
`endif
        ld = 32'd0;
        if (op == 6'b100011) ld = {mem_b[wb+3], mem_b[wb+2], mem_b[wb+1], mem_b[wb]};
        if (op == 6'b100001) ld = {{16{mem_b[hb+1][7]}}, mem_b[hb+1], mem_b[hb]};
        if (op == 6'b100101) ld = {16'd0, mem_b[hb+1], mem_b[hb]};
        if (op == 6'b100000) ld = {{24{mem_b[a][7]}}, mem_b[a]};
        if (op == 6'b100100) ld = {24'd0, mem_b[a]};
        if (mis) ld = 32'd0;
        if (!mis && op == 6'b101011) begin
            for (int k = 0; k < 4; k++) mem_b[wb+k] = sd[8*k +: 8];
        end
        if (!mis && op == 6'b101001) begin
            mem_b[hb] = sd[7:0];
            mem_b[hb+1] = sd[15:8];
        end
        if (op == 6'b101000) mem_b[a] = sd[7:0];
        if (op == 6'b000000) begin
            if (fn == 6'b001000 || fn == 6'b011000 || fn == 6'b011001 || fn == 6'b011010 ||
                fn == 6'b011011 || fn == 6'b010001 || fn == 6'b010011) who = 5'd0;
            else who = IR_E2M[15:11];
        end else if (is_ld || op[5:3] == 3'b001) who = rt;
        else if (op == 6'b000011) who = 5'd31;
        else who = 5'd0;
        chk("WhoNew_E2M", {27'd0, WhoNew_E2M}, {27'd0, who});
        chk("TNew_E2M", {30'd0, TNew_E2M}, is_ld ? 32'd1 : 32'd0);
        chk("AdErr_M", {31'd0, AdErr_M}, {31'd0, mis});
        e.ir = IR_E2M;
        e.pc4 = PC4_E2M;
        e.alu = ALUout_E2M;
        e.dm = ld;
        sb_q.push_back(e);
    endtask

    task automatic issue(input logic [31:0] ir, input logic [31:0] alu, input logic [31:0] rd2,
                         input logic [4:0] who_w, input logic [31:0] wd);
        @(negedge Clk);
        IR_E2M = ir;
        PC4_E2M = PC4_E2M + 32'd4;
        ALUout_E2M = alu;
        RD2_E2M = rd2;
        WhoNew_M2W = who_w;
        WD2A3 = wd;
        #1;
        model_step();
    endtask

    task automatic do_reset();
        in_rst = 1'b1;
        IR_E2M = 32'd0;
        ALUout_E2M = 32'd0;
        RD2_E2M = 32'd0;
        WhoNew_M2W = 5'd0;
        Reset = 1'b0;
        sb_q.delete();
        #1;
        chk("rst IR_M2W", IR_M2W, 32'd0);
        chk("rst PC4_M2W", PC4_M2W, 32'h0000_3004);
        chk("rst ALUout_M2W", ALUout_M2W, 32'd0);
        chk("rst DMout_M2W", DMout_M2W, 32'd0);
        for (int k = 0; k < 4096; k++) mem_b[k] = 8'd0;
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        in_rst = 1'b0;
        #1;
        model_step();
    endtask

    // Monitor: compare the M/W register against the oldest prediction.
    always @(posedge Clk) begin
        exp_t e;
        #1;
        if (!in_rst && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("IR_M2W", IR_M2W, e.ir);
            chk("PC4_M2W", PC4_M2W, e.pc4);
            chk("ALUout_M2W", ALUout_M2W, e.alu);
            chk("DMout_M2W", DMout_M2W, e.dm);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0]  ops [14];
        logic [31:0] ir;
        logic [31:0] ad;
        ops = '{6'b100011, 6'b100001, 6'b100101, 6'b100000, 6'b100100, 6'b101011,
                6'b101001, 6'b101000, 6'b000000, 6'b001000, 6'b001101, 6'b000011,
                6'b000100, 6'b000000};
        #2;
        do_reset();
        // Directed sequence around word 0x10.
        issue(itype(6'b101011, 5'd8, 16'h0010), 32'h10, 32'h1234_5678, 5'd0, 32'd0);
        issue(itype(6'b100011, 5'd9, 16'h0010), 32'h10, 32'd0, 5'd0, 32'd0);
        issue(itype(6'b101000, 5'd8, 16'h0013), 32'h13, 32'h0000_00AB, 5'd0, 32'd0);
        issue(itype(6'b100011, 5'd9, 16'h0010), 32'h10, 32'd0, 5'd0, 32'd0);
        issue(itype(6'b100000, 5'd9, 16'h0013), 32'h13, 32'd0, 5'd0, 32'd0);
        issue(itype(6'b100100, 5'd9, 16'h0013), 32'h13, 32'd0, 5'd0, 32'd0);
        issue(itype(6'b101001, 5'd8, 16'h0012), 32'h12, 32'h0000_8001, 5'd0, 32'd0);
        issue(itype(6'b100001, 5'd9, 16'h0012), 32'h12, 32'd0, 5'd0, 32'd0);
        issue(itype(6'b100101, 5'd9, 16'h0012), 32'h12, 32'd0, 5'd0, 32'd0);
        // Store-data forwarding from W, and no forwarding for rt = 0.
        issue(itype(6'b101011, 5'd8, 16'h0020), 32'h20, 32'd0, 5'd8, 32'hDEAD_BEEF);
        issue(itype(6'b100011, 5'd9, 16'h0020), 32'h20, 32'd0, 5'd0, 32'd0);
        issue(itype(6'b101011, 5'd0, 16'h0024), 32'h24, 32'h0000_0055, 5'd0, 32'hCAFE_F00D);
        issue(itype(6'b100011, 5'd9, 16'h0024), 32'h24, 32'd0, 5'd0, 32'd0);
        // Misaligned word store, then address wrap beyond the depth.
        issue(itype(6'b101011, 5'd8, 16'h0031), 32'h31, 32'hA5A5_5A5A, 5'd0, 32'd0);
        issue(itype(6'b100011, 5'd9, 16'h0030), 32'h30, 32'd0, 5'd0, 32'd0);
        issue(itype(6'b100001, 5'd9, 16'h0013), 32'h13, 32'd0, 5'd0, 32'd0);
        issue(itype(6'b101011, 5'd8, 16'h1010), 32'h1010, 32'h0BAD_F00D, 5'd0, 32'd0);
        issue(itype(6'b100011, 5'd9, 16'h0010), 32'h10, 32'd0, 5'd0, 32'd0);
        // Randomized traffic over a small window with random upper address bits.
        for (int n = 0; n < 400; n++) begin
            ir = $urandom;
            ir[31:26] = ops[$urandom_range(0, 13)];
            ad = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 127));
            issue(ir, ad, $urandom, ($urandom_range(0, 1) == 0) ? ir[20:16] : 5'($urandom_range(0, 31)),
                  $urandom);
            if (n == 250) begin
                do_reset();
                issue(itype(6'b100011, 5'd9, 16'h0010), 32'h10, 32'd0, 5'd0, 32'd0);
            end
        end
        issue(32'd0, 32'd0, 32'd0, 5'd0, 32'd0);
        repeat (3) @(posedge Clk);
        #2;
        chk("scoreboard drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
